// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and the printer blocks that feed it.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    // Arbiter FSM encodings; CR/LF are only reached when the line-ending option is built in.
    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_SEND = 3'd1,
        ARB_HOLD = 3'd2,
        ARB_CR   = 3'd3,
        ARB_LF   = 3'd4
    } arb_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Byte the arbiter emits on its own while in a line-ending state.
    function automatic logic [7:0] line_end_byte(input arb_state_t st);
        return (st == ARB_CR) ? ASCII_CR : ASCII_LF;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid searching upward from ptr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no bit of valid is set.
// Ports: valid (request vector), ptr (last served index), found, idx (chosen index).
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest offset back toward ptr+1 so the nearest valid index wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream sources, message-atomic round-robin.
// Latency: 1 cycle grant, then one byte per 2 cycles at best (strobe cycle + HOLD cycle).
// Backpressure: bytes only leave while tx_busy is low; the owner keeps the grant while stalled.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_last/req_ready per-lane source
//   handshake (req_ready is a one-cycle consume pulse); tx_data/new_tx_data/tx_busy to the UART;
//   grant_idx/grant_active expose the current owner.
// Option: define UART_TX_ARB_CRLF_EN to append CR, LF after every message's last byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic [PTR_W-1:0]     grant_idx,
    output logic                 grant_active
);

    arb_state_t       state, state_nxt;
    // Where HOLD goes next; captured when a byte is strobed so HOLD needs no extra decoding.
    arb_state_t       hold_next, hold_next_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] grant_idx_nxt;
    logic             grant_active_nxt;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;

    logic [7:0]       owner_dat;
    logic             owner_vld;
    logic             owner_last;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner lane mux.
    always_comb begin
        owner_dat  = '0;
        owner_vld  = 1'b0;
        owner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                owner_dat  = req_data[i*8 +: 8];
                owner_vld  = req_valid[i];
                owner_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            hold_next    <= ARB_IDLE;
            ptr          <= '0;
            grant_idx    <= '0;
            grant_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_next    <= hold_next_nxt;
            ptr          <= ptr_nxt;
            grant_idx    <= grant_idx_nxt;
            grant_active <= grant_active_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        hold_next_nxt    = hold_next;
        ptr_nxt          = ptr;
        grant_idx_nxt    = grant_idx;
        grant_active_nxt = grant_active;
        new_tx_data      = 1'b0;
        tx_data          = '0;
        req_ready        = '0;

        case (state)
            ARB_IDLE: begin
                // Grant cycle only; the first byte goes out from SEND at the earliest.
                if (pick_found) begin
                    grant_idx_nxt    = pick_idx;
                    grant_active_nxt = 1'b1;
                    state_nxt        = ARB_SEND;
                end
            end

            ARB_SEND: begin
                if (owner_vld && !tx_busy) begin
                    new_tx_data          = 1'b1;
                    tx_data              = owner_dat;
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ARB_HOLD;
`ifdef UART_TX_ARB_CRLF_EN
                    hold_next_nxt        = owner_last ? ARB_CR : ARB_SEND;
`else
                    hold_next_nxt        = owner_last ? ARB_IDLE : ARB_SEND;
`endif
                end
            end

            // One dead cycle after every strobe so tx_busy has time to rise.
            ARB_HOLD: begin
                state_nxt = hold_next;
                if (hold_next == ARB_IDLE) begin
                    grant_active_nxt = 1'b0;
                    ptr_nxt          = grant_idx;
                end
            end

`ifdef UART_TX_ARB_CRLF_EN
            ARB_CR, ARB_LF: begin
                if (!tx_busy) begin
                    new_tx_data   = 1'b1;
                    tx_data       = line_end_byte(state);
                    state_nxt     = ARB_HOLD;
                    hold_next_nxt = (state == ARB_CR) ? ARB_LF : ARB_IDLE;
                end
            end
`endif

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences, randomized traffic
// against a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_TX_ARB_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           new_tx_data;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_idx;
    logic           grant_active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .tx_busy      (tx_busy),
        .grant_idx    (grant_idx),
        .grant_active (grant_active)
    );

    typedef struct {
        logic [7:0] b;
        logic       l;
    } src_byte_t;

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] b;
    } out_t;

    typedef struct {
        logic [3:0]  vld, lst;
        logic [31:0] dat;
        logic        busy;
        logic        stb;
        logic [7:0]  txd;
        logic [3:0]  rdy;
        logic        ga;
        logic [1:0]  gi;
    } vec_t;

    src_byte_t src_q[N][$];   // what each source still has to present
    src_byte_t m_q[N][$];     // model copy of pending messages
    out_t      obs_q[$];
    out_t      exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    logic         auto_drive = 1'b0;
    logic         busy_force = 1'b1;
    logic         man_busy = 1'b0;
    logic [N-1:0] man_vld = '0, man_lst = '0;
    logic [31:0]  man_dat = '0;
    logic [N-1:0] gap_mask = '0;
    logic [N-1:0] ready_seen = '0;
    logic         strobe_seen = 1'b0;
    int           busy_cnt = 0;
    int           busy_max = 2;
    int           cyc = 0;
    int           last_stb = -10;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Input driver: sources present queue fronts, UART model raises tx_busy after strobes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_drive) begin
                for (int i = 0; i < N; i++)
                    if (ready_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                for (int i = 0; i < N; i++) begin
                    if (src_q[i].size() > 0 && !gap_mask[i]) begin
                        req_valid[i]       = 1'b1;
                        req_last[i]        = src_q[i][0].l;
                        req_data[i*8 +: 8] = src_q[i][0].b;
                    end else begin
                        req_valid[i]       = 1'b0;
                        req_last[i]        = 1'b0;
                        req_data[i*8 +: 8] = 8'h00;
                    end
                end
            end else begin
                req_valid = man_vld;
                req_last  = man_lst;
                req_data  = man_dat;
            end
            if (busy_force) begin
                tx_busy = man_busy;
            end else begin
                if (strobe_seen) busy_cnt = $urandom_range(busy_max, 1);
                else if (busy_cnt > 0) busy_cnt--;
                tx_busy = (busy_cnt > 0);
            end
        end
    end

    // Output monitor: per-cycle output rules and capture of the transmitted stream.
    initial begin
        out_t o;
        logic rdy_ok;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            ready_seen  = req_ready;
            strobe_seen = new_tx_data;
            if (new_tx_data) begin
                rdy_ok = (req_ready == (4'b0001 << grant_idx)) ||
                         (CRLF && req_ready == 4'b0000 && (tx_data == 8'h0D || tx_data == 8'h0A));
                check("strobe rules {busy,active,spacing,ready}",
                      {tx_busy, grant_active, (cyc - last_stb) >= 2, rdy_ok}, 4'b0111);
                o.src = 3'(grant_idx);
                o.b   = tx_data;
                obs_q.push_back(o);
                last_stb = cyc;
            end else begin
                check("quiet outputs {tx_data,req_ready}", {tx_data, req_ready}, 12'h000);
            end
        end
    end

    task automatic load(input int s, input logic [7:0] b, input logic l);
        src_byte_t e;
        e.b = b;
        e.l = l;
        src_q[s].push_back(e);
        m_q[s].push_back(e);
    endtask

    task automatic load_str(input int s, input string str);
        for (int k = 0; k < str.len(); k++) load(s, str[k], k == str.len() - 1);
    endtask

    // Message-level model: serve whole messages, next source is the first non-empty one after
    // the previously served source.
    task automatic model_arbitrate();
        int        s;
        src_byte_t e;
        out_t      o;
        bit        more;
        more = 1'b1;
        while (more) begin
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && m_q[(m_ptr + k) % N].size() > 0) s = (m_ptr + k) % N;
            if (s < 0) begin
                more = 1'b0;
            end else begin
                o.src = 3'(s);
                do begin
                    e   = m_q[s].pop_front();
                    o.b = e.b;
                    exp_q.push_back(o);
                end while (!e.l);
`ifdef UART_TX_ARB_CRLF_EN
                o.b = 8'h0D; exp_q.push_back(o);
                o.b = 8'h0A; exp_q.push_back(o);
`endif
                m_ptr = s;
            end
        end
    endtask

    task automatic drain(input string nm, input int first_src);
        bit done;
        int n;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            #3;
            if (obs_q.size() >= exp_q.size() && !grant_active) done = 1'b1;
        end
        check({nm, " finished within budget"}, done, 1'b1);
        check({nm, " byte count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte %0d {src,data}", nm, i), obs_q[i], exp_q[i]);
        if (first_src >= 0 && obs_q.size() > 0)
            check({nm, " first owner"}, obs_q[0].src, first_src);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_obs(input string nm, input int cnt);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            #3;
            if (obs_q.size() >= cnt) seen = 1'b1;
        end
        check({nm, " strobes seen"}, seen, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   stall_bad;
        bit   seen;
        int   nm, len;

        repeat (3) @(negedge clk);
        #1;
        check("reset outputs {stb,data,ready,active,idx}",
              {new_tx_data, tx_data, req_ready, grant_active, grant_idx}, 16'h0000);
        rst = 1'b0;

`ifndef UART_TX_ARB_CRLF_EN
        //          vld      last     lanes         busy  stb   txd    rdy      ga    gi
        tbl[0]  = '{4'b0001, 4'b0000, 32'h0000_0041, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0001, 4'b0000, 32'h0000_0041, 1'b0, 1'b1, 8'h41, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b0001, 4'b0001, 32'h0000_0042, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd0};
        tbl[3]  = '{4'b0001, 4'b0001, 32'h0000_0042, 1'b0, 1'b1, 8'h42, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b0100, 4'b0100, 32'h0078_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[7]  = '{4'b0100, 4'b0100, 32'h0078_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd2};
        tbl[8]  = '{4'b0100, 4'b0100, 32'h0078_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd2};
        tbl[9]  = '{4'b0100, 4'b0100, 32'h0078_0000, 1'b0, 1'b1, 8'h78, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd2};
        tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
        for (int k = 0; k < 12; k++) begin
            man_vld  = tbl[k].vld;
            man_lst  = tbl[k].lst;
            man_dat  = tbl[k].dat;
            man_busy = tbl[k].busy;
            @(negedge clk);
            #1;
            check($sformatf("vec%0d {stb,data,ready,active,idx}", k),
                  {new_tx_data, tx_data, req_ready, grant_active, grant_idx},
                  {tbl[k].stb, tbl[k].txd, tbl[k].rdy, tbl[k].ga, tbl[k].gi});
        end
        man_vld  = '0;
        man_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        m_ptr = 0;
`endif

        auto_drive = 1'b1;
        busy_force = 1'b0;
        busy_max   = 2;

        // Tie between 1 and 2 from ptr 0, then 0/1/3 tie after 2 was served.
        load_str(1, "12");
        load_str(2, "3");
        model_arbitrate();
        drain("tie 1/2", 1);
        load_str(1, "x");
        load_str(3, "y");
        load_str(0, "w");
        model_arbitrate();
        drain("tie 0/1/3", 3);

        // UART busy for 50 cycles while the owner waits in SEND.
        busy_force = 1'b1;
        man_busy   = 1'b1;
        load_str(2, "Q");
        model_arbitrate();
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            #1;
            if (grant_active) seen = 1'b1;
        end
        check("busy test grant taken", seen, 1'b1);
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (new_tx_data || req_ready != 4'b0000) stall_bad++;
        end
        check("busy stall cycles with output", stall_bad, 0);
        man_busy = 1'b0;
        @(negedge clk);
        #1;
        check("busy release strobe {stb,data,ready}", {new_tx_data, tx_data, req_ready},
              {1'b1, 8'h51, 4'b0100});
        busy_force = 1'b0;
        drain("busy release", 2);

        // Owner stalls mid-message while source 3 waits.
        load_str(0, "abc");
        model_arbitrate();
        wait_obs("owner stall", 1);
        gap_mask = 4'b0001;
        load_str(3, "z");
        model_arbitrate();
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (new_tx_data || req_ready[3] || !grant_active || grant_idx != 2'd0) stall_bad++;
        end
        check("owner stall cycles not held", stall_bad, 0);
        gap_mask = 4'b0000;
        drain("owner stall", 0);

        // Reset in the middle of a message from source 1 (rr pointer is 3 here).
        src_q[1].push_back('{8'h4C, 1'b0});
        src_q[1].push_back('{8'h4D, 1'b0});
        src_q[1].push_back('{8'h4E, 1'b1});
        wait_obs("mid-message reset", 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset mid-message {stb,data,ready,active,idx}",
              {new_tx_data, tx_data, req_ready, grant_active, grant_idx}, 16'h0000);
        check("bytes before reset", obs_q.size(), 2);
        for (int i = 0; i < N; i++) src_q[i].delete();
        obs_q.delete();
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        load_str(0, "r");
        load_str(1, "s");
        model_arbitrate();
        drain("after reset", 1);

`ifdef UART_TX_ARB_CRLF_EN
        load_str(0, "7");
        model_arbitrate();
        drain("crlf single byte", 0);
`endif

        // Randomized traffic against the message-level model.
        for (int r = 0; r < 6; r++) begin
            busy_max = $urandom_range(4, 1);
            for (int s = 0; s < N; s++) begin
                nm = $urandom_range(2, 0);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++)
                        load(s, 8'($urandom_range(126, 32)), k == len - 1);
                end
            end
            model_arbitrate();
            drain($sformatf("random round %0d", r), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
